// File: rtl/ship_life_ctl.sv
// Player ship life-cycle FSM: ALIVE -> EXPLODE -> RESPAWN -> ALIVE, or GAME_OVER, timed in vsync frames.
// Optional respawn blink is enabled by defining SHIP_BLINK_EN.
module ship_life_ctl #(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_W        = 3,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_FRAMES   = 8,
  parameter int CNT_W          = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               hit,
  input  logic               restart,
  output logic               ship_dead,
  output logic               ship_visible,
  output logic               invuln,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_EXPLODE   = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_RST    = LIVES_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]   EXPLODE_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   INVULN_LAST  = CNT_W'(INVULN_FRAMES - 1);

  if (LIVES_INIT < 1 || LIVES_INIT >= (1 << LIVES_W)) begin : g_bad_lives
    $error("ship_life_ctl: LIVES_INIT out of range");
  end
  if (EXPLODE_FRAMES < 1 || INVULN_FRAMES < 1 || BLINK_FRAMES < 1 ||
      EXPLODE_FRAMES > (1 << CNT_W) || INVULN_FRAMES > (1 << CNT_W) ||
      BLINK_FRAMES > (1 << CNT_W)) begin : g_bad_frames
    $error("ship_life_ctl: frame parameter out of range");
  end

  state_t           st;
  logic             vsync_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             tick;

`ifdef SHIP_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  logic [CNT_W-1:0] blink_cnt;
`endif

  assign tick  = vsync_in & ~vsync_q;
  assign state = st;

  // NOTE: every register below is assigned with <= so all of them see the same pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      st           <= ST_ALIVE;
      lives        <= LIVES_RST;
      ship_dead    <= 1'b0;
      ship_visible <= 1'b1;
      invuln       <= 1'b0;
      game_over    <= 1'b0;
      frame_cnt    <= '0;
      vsync_q      <= 1'b0;
`ifdef SHIP_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
      vsync_q <= vsync_in;
      case (st)
        // Leaving ALIVE on the same edge is what makes a held hit cost only one life.
        ST_ALIVE: begin
          if (hit) begin
            lives        <= lives - LIVES_W'(1);
            ship_dead    <= 1'b1;
            ship_visible <= 1'b0;
            frame_cnt    <= '0;
            if (lives == LIVES_W'(1)) begin
              st        <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              st <= ST_EXPLODE;
            end
          end
        end

        ST_EXPLODE: begin
          if (tick) begin
            if (frame_cnt == EXPLODE_LAST) begin
              st           <= ST_RESPAWN;
              frame_cnt    <= '0;
              ship_dead    <= 1'b0;
              ship_visible <= 1'b1;
              invuln       <= 1'b1;
`ifdef SHIP_BLINK_EN
              blink_cnt    <= '0;
`endif
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end

        ST_RESPAWN: begin
          if (tick) begin
            if (frame_cnt == INVULN_LAST) begin
              st           <= ST_ALIVE;
              frame_cnt    <= '0;
              invuln       <= 1'b0;
              ship_visible <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
`ifdef SHIP_BLINK_EN
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                ship_visible <= ~ship_visible;
              end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
              end
`endif
            end
          end
        end

        ST_GAME_OVER: begin
          if (restart) begin
            st           <= ST_ALIVE;
            lives        <= LIVES_RST;
            game_over    <= 1'b0;
            frame_cnt    <= '0;
            ship_dead    <= 1'b0;
            ship_visible <= 1'b1;
          end
        end

        default: st <= ST_ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_life_ctl.sv
// Directed bench for ship_life_ctl; expected output snapshots are hand-computed
// as {state, lives, ship_dead, ship_visible, invuln, game_over}.
module tb_ship_life_ctl;

  logic       pclk = 1'b0;
  logic       rst, vsync_in, hit, restart;
  logic       ship_dead, ship_visible, invuln, game_over;
  logic [2:0] lives;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  ship_life_ctl #(
    .LIVES_INIT    (2),
    .LIVES_W       (3),
    .EXPLODE_FRAMES(4),
    .INVULN_FRAMES (6),
    .BLINK_FRAMES  (2),
    .CNT_W         (8)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .hit         (hit),
    .restart     (restart),
    .ship_dead   (ship_dead),
    .ship_visible(ship_visible),
    .invuln      (invuln),
    .lives       (lives),
    .game_over   (game_over),
    .state       (state)
  );

  always #5 pclk = ~pclk;

  function automatic logic [8:0] snap();
    return {state, lives, ship_dead, ship_visible, invuln, game_over};
  endfunction

  function automatic logic [8:0] mk(logic [1:0] s, logic [2:0] l,
                                    logic d, logic v, logic i, logic g);
    return {s, l, d, v, i, g};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic frame_tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [8:0] exp_v;
    rst = 1'b1; vsync_in = 1'b0; hit = 1'b0; restart = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    exp_v = mk(2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", snap(), exp_v);
    end
  endtask

  task automatic test_hit_explode();
    logic [8:0] exp_v;
    hit = 1'b1; step(); hit = 1'b0;
    exp_v = mk(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL hit_enters_explode: got %b expected %b", snap(), exp_v);
    end
    hit = 1'b1; step(); hit = 1'b0;
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL hit_ignored_in_explode: got %b expected %b", snap(), exp_v);
    end
    repeat (3) frame_tick();
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL explode_after_3_ticks: got %b expected %b", snap(), exp_v);
    end
    frame_tick();
    exp_v = mk(2'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL respawn_after_4_ticks: got %b expected %b", snap(), exp_v);
    end
  endtask

  task automatic test_respawn_hit();
    logic [5:0] vis_pat;
    logic [8:0] exp_v;
`ifdef SHIP_BLINK_EN
    vis_pat = 6'b110011;
`else
    vis_pat = 6'b111111;
`endif
    hit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_v = mk(2'd2, 3'd1, 1'b0, vis_pat[i], 1'b1, 1'b0);
      n_checks++;
      if (snap() !== exp_v) begin
        n_fail++;
        $display("FAIL respawn_frame_%0d: got %b expected %b", i, snap(), exp_v);
      end
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      if (i == 5) hit = 1'b0;
      step();
    end
    exp_v = mk(2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL respawn_to_alive: got %b expected %b", snap(), exp_v);
    end
  endtask

  task automatic test_game_over();
    logic [8:0] exp_v;
    hit = 1'b1;
    repeat (10) step();
    hit = 1'b0;
    exp_v = mk(2'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL held_hit_game_over: got %b expected %b", snap(), exp_v);
    end
    frame_tick();
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL game_over_holds: got %b expected %b", snap(), exp_v);
    end
    restart = 1'b1; step(); restart = 1'b0;
    exp_v = mk(2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_from_game_over: got %b expected %b", snap(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_v;
    restart = 1'b1; step(); restart = 1'b0;
    exp_v = mk(2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_ignored_alive: got %b expected %b", snap(), exp_v);
    end
    hit = 1'b1; vsync_in = 1'b1; step(); hit = 1'b0; vsync_in = 1'b0;
    exp_v = mk(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL hit_beats_tick: got %b expected %b", snap(), exp_v);
    end
    step();
    restart = 1'b1; step(); restart = 1'b0;
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL restart_ignored_explode: got %b expected %b", snap(), exp_v);
    end
    repeat (3) frame_tick();
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL frame_cnt_zero_on_entry: got %b expected %b", snap(), exp_v);
    end
    frame_tick();
    exp_v = mk(2'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL respawn_after_hit_tick: got %b expected %b", snap(), exp_v);
    end
    repeat (6) frame_tick();
    exp_v = mk(2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL alive_after_invuln: got %b expected %b", snap(), exp_v);
    end
  endtask

  task automatic test_reset_mid_explode();
    logic [8:0] exp_v;
    rst = 1'b1; step(); rst = 1'b0;
    hit = 1'b1; step(); hit = 1'b0;
    repeat (2) frame_tick();
    exp_v = mk(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL explode_before_rst: got %b expected %b", snap(), exp_v);
    end
    rst = 1'b1; step(); rst = 1'b0;
    exp_v = mk(2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_explode: got %b expected %b", snap(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_hit_explode();
    test_respawn_hit();
    test_game_over();
    test_back_to_back();
    test_reset_mid_explode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
